store_writer: RTL and testbench
===============================

Name: store_writer

Overview:
- Memory-side consumer of the ROB store-commit interface.
- Accepts one committed store per handshake: `store_type`, `data_addr` and `value`. Writes it to the byte-wide RAM port one byte per cycle, little-endian.
- Drives the `mem_busy` signal that the ROB samples before committing the next store.
- Sits between ROB commit and RAM arbitration. A committed store is never aborted by a flush.

Parameters:
- ADDR_WIDTH, 32, width of the RAM address output and latched address.
- IO_ADDR_MASK, 32'h00030000, address bits that identify the MMIO region; region is hit when `(addr & IO_ADDR_MASK) == IO_ADDR_MASK`.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  reset, asynchronous, active-low (0 = reset).
- rdy_in  in  1  global ready; 0 freezes all state.
- rob_ready_in  in  1  store-commit pulse from ROB.
- store_type_in  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- data_addr_in  in  32  store byte address.
- value_in  in  32  store data.
- flush_in  in  1  pipeline flush; ignored by this block apart from the documented point below.
- io_buffer_full_in  in  1  MMIO output buffer full.
- mem_busy_out  out  1  combinational: `rob_ready_in | (state != IDLE)`.
- mem_a_out  out  ADDR_WIDTH  RAM byte address.
- mem_dout  out  8  RAM write data.
- mem_wr_out  out  1  RAM write enable.
- store_done_out  out  1  one-cycle pulse when the last byte is written.

Behaviour:
- Reset (`rst_in = 0`, async):
  - state = IDLE.
  - `mem_wr_out`, `store_done_out`, `mem_a_out`, `mem_dout` = 0.
  - byte counter = 0.
- `rdy_in = 0`: all registers hold, including the outputs. `mem_busy_out` still follows its equation.
- States: IDLE, WAIT_IO, WRITE. Byte count n = 1 / 2 / 4 for type 00 / 01 / (10, 11).
- IDLE, `rob_ready_in = 1` at an edge:
  - Latch addr, value, n; `store_done_out <= 0`.
  - If the address is in the MMIO region and `io_buffer_full_in = 1`: go to WAIT_IO with `mem_wr_out <= 0`.
  - Otherwise go to WRITE and drive `mem_a_out <= addr`, `mem_dout <= value[7:0]`, `mem_wr_out <= 1`, counter <= 1.
- WAIT_IO:
  - Holds with `mem_wr_out = 0` while `io_buffer_full_in = 1`.
  - At the first edge with `io_buffer_full_in = 0`: drive byte 0 exactly as above and go to WRITE.
- WRITE, counter k < n at an edge:
  - `mem_a_out <= addr + k` (32-bit modular add, no carry out).
  - `mem_dout <= value[8k+7:8k]`, `mem_wr_out <= 1`, counter <= k + 1.
- WRITE, k == n at an edge: `mem_wr_out <= 0`, `store_done_out <= 1`, state <= IDLE.
- Word store timing: bytes appear on edges E0..E3; `mem_wr_out` falls and `store_done_out` pulses at E4. `mem_busy_out` is high from the `rob_ready_in` cycle through the cycle before E4. That is 5 edges total per word, 2 per byte store.
- The new acceptance is only checked in IDLE. A store accepted at edge E4 after a previous store is legal: `store_done_out` is cleared and the new store starts. That back-to-back case cannot occur through the ROB while busy is held.
- `rob_ready_in` while not IDLE is a protocol violation. It is ignored: no latch, no state change.
- `flush_in` has no effect in any state. An in-flight or waiting store always completes, because it is already committed.
- Address wrap: `addr + k` wraps modulo 2^32.
- The MMIO check is done once, at acceptance or in WAIT_IO. `io_buffer_full_in` asserting mid-WRITE does not pause the store.

Test Plan:
- Word store: type 10, addr 0x00001000, value 0xDEADBEEF -> writes (0x1000, EF), (0x1001, BE), (0x1002, AD), (0x1003, DE) on 4 consecutive edges; `store_done_out` pulses at the 5th edge; busy is high in the ready cycle through the write cycles.
- Byte and half stores: type 00, addr 0x20, value 0x12345678 -> a single write of 0x78 at 0x20. Type 01, addr 0x7FFF, value 0xABCD -> 0xCD at 0x7FFF, then 0xAB at 0x8000.
- MMIO stall: type 00, addr 0x00030000, value 0x41, `io_buffer_full_in = 1` for 3 cycles -> `mem_wr_out` stays 0 and busy stays 1; the write of 0x41 happens at the first edge after full drops.
- Flush plus reset: `flush_in = 1` during the 2nd byte of a word store -> all 4 bytes are still written. Separately, `rst_in` driven low mid-store -> outputs go to 0 immediately (async) and state = IDLE.
- Wrap and protocol: word store at 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001. A second `rob_ready_in` pulse during WRITE -> ignored; the first store's data is unchanged.
- `rdy_in = 0` for 2 cycles mid-store -> counter and outputs freeze; the remaining bytes complete after `rdy_in` returns to 1.

Source files
------------

// File: rtl/store_writer.sv
`timescale 1ns/1ps
// store_writer: memory-side consumer of the ROB store-commit interface.
// Takes one committed store per handshake and writes it to a byte-wide
// RAM port, one byte per cycle, little-endian. Stores that target the
// MMIO region wait while the MMIO output buffer is full. A committed
// store is never aborted by a flush.
module store_writer #(
  parameter int          ADDR_WIDTH   = 32,
  parameter logic [31:0] IO_ADDR_MASK = 32'h00030000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rob_ready_in,
  input  logic [1:0]            store_type_in,
  input  logic [31:0]           data_addr_in,
  input  logic [31:0]           value_in,
  input  logic                  flush_in,
  input  logic                  io_buffer_full_in,
  output logic                  mem_busy_out,
  output logic [ADDR_WIDTH-1:0] mem_a_out,
  output logic [7:0]            mem_dout,
  output logic                  mem_wr_out,
  output logic                  store_done_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IO = 2'd1,
    WRITE   = 2'd2
  } state_t;

  // Number of bytes to write for a given store type; 11 behaves as a word.
  function automatic logic [2:0] byte_count(input logic [1:0] store_type);
    logic [2:0] n;
    case (store_type)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Little-endian byte lane selection from the latched store value.
  function automatic logic [7:0] byte_sel(input logic [31:0] value, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = value[7:0];
      3'd1:    b = value[15:8];
      3'd2:    b = value[23:16];
      3'd3:    b = value[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [31:0]           value_r, value_s;
  logic [2:0]            nbytes_r, nbytes_s;
  logic [2:0]            cnt_r, cnt_s;
  logic [ADDR_WIDTH-1:0] mem_a_s;
  logic [7:0]            mem_dout_s;
  logic                  mem_wr_s;
  logic                  store_done_s;
  logic                  in_mmio_s;
  logic                  unused_flush_s;

  // Flush is deliberately ignored: every store reaching here is already committed.
  assign unused_flush_s = flush_in;

  assign in_mmio_s    = ((data_addr_in & IO_ADDR_MASK) == IO_ADDR_MASK);
  assign mem_busy_out = rob_ready_in | (state_r != IDLE);

  // Next-state and next-output logic for the store sequencer.
  always_comb begin
    state_s      = state_r;
    addr_s       = addr_r;
    value_s      = value_r;
    nbytes_s     = nbytes_r;
    cnt_s        = cnt_r;
    mem_a_s      = mem_a_out;
    mem_dout_s   = mem_dout;
    mem_wr_s     = mem_wr_out;
    store_done_s = store_done_out;
    case (state_r)
      IDLE: begin
        mem_wr_s     = 1'b0;
        store_done_s = 1'b0;
        if (rob_ready_in) begin
          addr_s   = data_addr_in[ADDR_WIDTH-1:0];
          value_s  = value_in;
          nbytes_s = byte_count(store_type_in);
          if (in_mmio_s && io_buffer_full_in) begin
            state_s = WAIT_IO;
          end else begin
            state_s    = WRITE;
            mem_a_s    = data_addr_in[ADDR_WIDTH-1:0];
            mem_dout_s = value_in[7:0];
            mem_wr_s   = 1'b1;
            cnt_s      = 3'd1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_IO: begin
        if (!io_buffer_full_in) begin
          state_s    = WRITE;
          mem_a_s    = addr_r;
          mem_dout_s = byte_sel(value_r, 3'd0);
          mem_wr_s   = 1'b1;
          cnt_s      = 3'd1;
        end else begin
          mem_wr_s = 1'b0;
        end
      end
      WRITE: begin
        if (cnt_r < nbytes_r) begin
          mem_a_s    = addr_r + ADDR_WIDTH'(cnt_r);
          mem_dout_s = byte_sel(value_r, cnt_r);
          mem_wr_s   = 1'b1;
          cnt_s      = cnt_r + 3'd1;
        end else begin
          mem_wr_s     = 1'b0;
          store_done_s = 1'b1;
          state_s      = IDLE;
        end
      end
      default: begin
        state_s      = IDLE;
        mem_wr_s     = 1'b0;
        store_done_s = 1'b0;
      end
    endcase
  end

  // State and output registers; rdy_in low freezes everything.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r        <= IDLE;
      addr_r         <= '0;
      value_r        <= 32'h0000_0000;
      nbytes_r       <= 3'd0;
      cnt_r          <= 3'd0;
      mem_a_out      <= '0;
      mem_dout       <= 8'h00;
      mem_wr_out     <= 1'b0;
      store_done_out <= 1'b0;
    end else if (rdy_in) begin
      state_r        <= state_s;
      addr_r         <= addr_s;
      value_r        <= value_s;
      nbytes_r       <= nbytes_s;
      cnt_r          <= cnt_s;
      mem_a_out      <= mem_a_s;
      mem_dout       <= mem_dout_s;
      mem_wr_out     <= mem_wr_s;
      store_done_out <= store_done_s;
    end
  end

endmodule

// File: tb/tb_store_writer.sv
`timescale 1ns/1ps
// Self-checking bench for store_writer: table of directed stores, random
// stores against a byte-sequence reference model, and an async reset case.
module tb_store_writer;

  localparam logic [31:0] MASK = 32'h00030000;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        rob_ready_in = 1'b0;
  logic [1:0]  store_type_in = 2'b00;
  logic [31:0] data_addr_in = 32'h0;
  logic [31:0] value_in = 32'h0;
  logic        flush_in = 1'b0;
  logic        io_buffer_full_in = 1'b0;
  logic        mem_busy_out;
  logic [31:0] mem_a_out;
  logic [7:0]  mem_dout;
  logic        mem_wr_out;
  logic        store_done_out;

  int errors = 0;
  int checks = 0;

  store_writer #(.ADDR_WIDTH(32), .IO_ADDR_MASK(MASK)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_ready_in(rob_ready_in),
    .store_type_in(store_type_in), .data_addr_in(data_addr_in), .value_in(value_in),
    .flush_in(flush_in), .io_buffer_full_in(io_buffer_full_in),
    .mem_busy_out(mem_busy_out), .mem_a_out(mem_a_out), .mem_dout(mem_dout),
    .mem_wr_out(mem_wr_out), .store_done_out(store_done_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [1:0]  t;
    logic [31:0] a;
    logic [31:0] v;
    int          full;     // edges with io_buffer_full_in high, starting at acceptance
    int          frz_at;   // bytes written before rdy_in is dropped
    int          frz_len;  // edges with rdy_in low
    bit          flush;    // flush during the 2nd byte
    bit          proto;    // stray rob_ready_in during WRITE
    bit          io_mid;   // io_buffer_full_in high during WRITE
    int          exp_n;
    logic [7:0]  exp_b0;
    logic [31:0] exp_alast;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: a store is just n little-endian bytes at consecutive addresses.
  function automatic int model_n(input logic [1:0] t);
    return (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [7:0] model_byte(input logic [31:0] v, input int k);
    logic [31:0] sh;
    sh = v >> (8 * k);
    return sh[7:0];
  endfunction

  // Issues one store from a negedge in IDLE and checks every cycle until done.
  task automatic run_store(input vec_t c, output int obs_n, output logic [7:0] obs_b0,
                           output logic [31:0] obs_alast);
    int n, stall, k, cyc, fz;
    bit mmio, done_seen, froze;
    logic [31:0] prev_a;
    logic [7:0]  prev_d;
    n = model_n(c.t);
    mmio = ((c.a & MASK) == MASK);
    stall = (mmio && c.full > 0) ? c.full : 0;
    obs_n = 0; obs_b0 = 8'h0; obs_alast = 32'h0;
    rob_ready_in = 1'b1; store_type_in = c.t; data_addr_in = c.a; value_in = c.v;
    io_buffer_full_in = (c.full > 0); rdy_in = 1'b1; flush_in = 1'b0;
    #1;
    chk("busy_accept", 32'(mem_busy_out), 32'd1);
    @(posedge clk_in); @(negedge clk_in);
    rob_ready_in = 1'b0; data_addr_in = $urandom; value_in = $urandom; store_type_in = 2'($urandom);
    for (int i = 0; i < stall; i++) begin
      chk("stall_wr", 32'(mem_wr_out), 32'd0);
      chk("stall_busy", 32'(mem_busy_out), 32'd1);
      chk("stall_done", 32'(store_done_out), 32'd0);
      io_buffer_full_in = (i < stall - 1);
      @(posedge clk_in); @(negedge clk_in);
    end
    io_buffer_full_in = c.io_mid;
    k = 0; cyc = 0; fz = 0; done_seen = 1'b0; froze = 1'b0; prev_a = 32'h0; prev_d = 8'h0;
    while (!done_seen && cyc < 16) begin
      if (froze) begin
        chk("freeze_wr", 32'(mem_wr_out), 32'd1);
        chk("freeze_addr", mem_a_out, prev_a);
        chk("freeze_data", 32'(mem_dout), 32'(prev_d));
        chk("freeze_busy", 32'(mem_busy_out), 32'd1);
      end else if (mem_wr_out) begin
        if (k >= n) begin
          chk("byte_overrun", 32'(k + 1), 32'(n));
        end else begin
          chk("write_addr", mem_a_out, c.a + 32'(k));
          chk("write_data", 32'(mem_dout), 32'(model_byte(c.v, k)));
        end
        chk("busy_write", 32'(mem_busy_out), 32'd1);
        chk("done_early", 32'(store_done_out), 32'd0);
        if (k == 0) obs_b0 = mem_dout;
        obs_alast = mem_a_out;
        k++;
      end else begin
        chk("done_pulse", 32'(store_done_out), 32'd1);
        chk("busy_end", 32'(mem_busy_out), 32'd0);
        done_seen = 1'b1;
      end
      prev_a = mem_a_out; prev_d = mem_dout;
      if (!done_seen) begin
        froze = (k == c.frz_at) && (fz < c.frz_len);
        if (froze) fz++;
        rdy_in = !froze;
        flush_in = c.flush && (k == 2);
        if (c.proto && k == 2 && n == 4) begin
          rob_ready_in = 1'b1; data_addr_in = $urandom; value_in = $urandom; store_type_in = 2'b00;
        end else begin
          rob_ready_in = 1'b0;
        end
        @(posedge clk_in); @(negedge clk_in);
        cyc++;
      end
    end
    if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
    obs_n = k;
    chk("byte_count", 32'(k), 32'(n));
    rdy_in = 1'b1; flush_in = 1'b0; rob_ready_in = 1'b0; io_buffer_full_in = 1'b0;
    @(posedge clk_in); @(negedge clk_in);
    chk("done_clear", 32'(store_done_out), 32'd0);
    chk("wr_idle", 32'(mem_wr_out), 32'd0);
  endtask

  initial begin
    int on;
    logic [7:0]  ob0;
    logic [31:0] oal;
    vec_t r;

    //             t      addr          value          full frz  len fl pr io  n  b0     alast
    vecs[0]  = '{2'b10, 32'h00001000, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 4, 8'hEF, 32'h00001003};
    vecs[1]  = '{2'b00, 32'h00000020, 32'h12345678, 0, 0, 0, 0, 0, 0, 1, 8'h78, 32'h00000020};
    vecs[2]  = '{2'b01, 32'h00007FFF, 32'h0000ABCD, 0, 0, 0, 0, 0, 0, 2, 8'hCD, 32'h00008000};
    vecs[3]  = '{2'b00, 32'h00030000, 32'h00000041, 3, 0, 0, 0, 0, 0, 1, 8'h41, 32'h00030000};
    vecs[4]  = '{2'b10, 32'h00002000, 32'h11223344, 0, 0, 0, 1, 0, 0, 4, 8'h44, 32'h00002003};
    vecs[5]  = '{2'b10, 32'hFFFFFFFE, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 4, 8'h0D, 32'h00000001};
    vecs[6]  = '{2'b10, 32'h00003000, 32'h01020304, 0, 0, 0, 0, 1, 0, 4, 8'h04, 32'h00003003};
    vecs[7]  = '{2'b10, 32'h00004000, 32'hA1B2C3D4, 0, 2, 2, 0, 0, 0, 4, 8'hD4, 32'h00004003};
    vecs[8]  = '{2'b11, 32'h00005000, 32'h55667788, 0, 0, 0, 0, 0, 0, 4, 8'h88, 32'h00005003};
    vecs[9]  = '{2'b01, 32'h00030010, 32'h0000BEEF, 0, 0, 0, 0, 0, 1, 2, 8'hEF, 32'h00030011};
    vecs[10] = '{2'b00, 32'h00020000, 32'h00000099, 2, 0, 0, 0, 0, 0, 1, 8'h99, 32'h00020000};

    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_wr", 32'(mem_wr_out), 32'd0);
    chk("rst_done", 32'(store_done_out), 32'd0);
    chk("rst_addr", mem_a_out, 32'd0);
    chk("rst_data", 32'(mem_dout), 32'd0);
    chk("rst_busy", 32'(mem_busy_out), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);

    // Directed table
    for (int i = 0; i < 11; i++) begin
      run_store(vecs[i], on, ob0, oal);
      chk($sformatf("vec%0d_n", i), 32'(on), 32'(vecs[i].exp_n));
      chk($sformatf("vec%0d_b0", i), 32'(ob0), 32'(vecs[i].exp_b0));
      chk($sformatf("vec%0d_alast", i), oal, vecs[i].exp_alast);
    end

    // Randomized stores against the reference model
    for (int i = 0; i < 40; i++) begin
      r.t = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: r.a = $urandom;
        1: r.a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
        default: r.a = $urandom | MASK;
      endcase
      r.v = $urandom;
      r.full = $urandom_range(0, 3);
      r.frz_at = $urandom_range(1, model_n(r.t));
      r.frz_len = $urandom_range(0, 2);
      r.flush = 1'($urandom_range(0, 1));
      r.proto = 1'($urandom_range(0, 1));
      r.io_mid = 1'($urandom_range(0, 1));
      r.exp_n = model_n(r.t); r.exp_b0 = model_byte(r.v, 0); r.exp_alast = r.a + 32'(r.exp_n - 1);
      run_store(r, on, ob0, oal);
      chk("rand_alast", oal, r.exp_alast);
    end

    // Asynchronous reset in the middle of a word store
    rob_ready_in = 1'b1; store_type_in = 2'b10; data_addr_in = 32'h00006000; value_in = 32'h89ABCDEF;
    @(posedge clk_in); @(negedge clk_in);
    rob_ready_in = 1'b0;
    @(posedge clk_in); #2;
    rst_in = 1'b0;
    #1;
    chk("arst_wr", 32'(mem_wr_out), 32'd0);
    chk("arst_addr", mem_a_out, 32'd0);
    chk("arst_data", 32'(mem_dout), 32'd0);
    chk("arst_done", 32'(store_done_out), 32'd0);
    chk("arst_busy", 32'(mem_busy_out), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in); @(negedge clk_in);
    chk("arst_idle_wr", 32'(mem_wr_out), 32'd0);
    chk("arst_idle_busy", 32'(mem_busy_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
